// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared types and helpers for the iterative RV32M multiply/divide unit.
//   mdu_op_e    : M-extension funct3 encodings (MDU_MUL..MDU_REMU).
//   mdu_state_e : FSM state encodings (IDLE, BUSY, DONE).
//   op_* funcs  : operation-class decode used by the FSM and the datapath.
package mdu_iter_pkg;

    typedef enum logic [2:0] {
        MduMul    = 3'b000,
        MduMulh   = 3'b001,
        MduMulhsu = 3'b010,
        MduMulhu  = 3'b011,
        MduDiv    = 3'b100,
        MduDivu   = 3'b101,
        MduRem    = 3'b110,
        MduRemu   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } mdu_state_e;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic op_is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_rs1_signed(input mdu_op_e op);
        return (op == MduMulh) || (op == MduMulhsu) || (op == MduDiv) || (op == MduRem);
    endfunction

    // MULHSU deliberately treats rs2 as unsigned.
    function automatic logic op_rs2_signed(input mdu_op_e op);
        return (op == MduMulh) || (op == MduDiv) || (op == MduRem);
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: shared radix-2 datapath for mdu_iter.
//   The {hi, lo} register pair is the 2*XLEN product accumulator for multiply and the
//   {remainder, quotient} pair for divide.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : load operands (hi cleared, lo <= a_i, divisor/multiplicand <= b_i)
//   step_i         : perform one radix-2 iteration
//   is_div_i       : 1 = restoring shift-subtract, 0 = shift-add multiply
//   a_i, b_i       : operand magnitudes
//   hi_o, lo_o     : product high/low word, or remainder/quotient
module mdu_shift_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   sum;

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        rem_shift = {hi_q, lo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, b_q};
        sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        if (start_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Borrow out of the trial subtract means the divisor did not fit: restore.
                if (!trial[XLEN]) begin
                    hi_d = trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = rem_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                // Multiplier bits are consumed from lo's LSB as product bits shift in from hi.
                {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit in the EX stage.
//   Accepts an M-extension op from EX, stalls the front of the pipe while a radix-2
//   multiply or restoring divide runs, then presents the result for one cycle.
//   Divide-by-zero and signed overflow bypass the iterative core.
// Build option:
//   MDU_FAST_MUL_EN : MUL* complete combinationally in the accept cycle; only DIV/REM
//                     use the FSM. Undefined: every op is iterative.
// Ports:
//   clk_i, rst_n_i  : clock, asynchronous active-low reset
//   valid_i         : EX holds an M-extension instruction
//   op_i            : funct3 (MUL..REMU)
//   rs1_i, rs2_i    : forwarded operands
//   kill_i          : abort in-flight op (trap/flush)
//   result_o        : result, valid when result_valid_o; holds last value otherwise
//   result_valid_o  : result_o valid this cycle
//   stall_o         : multi-cycle stall request to hazard unit
//   busy_o          : FSM not IDLE
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            stall_o,
    output logic            busy_o
);

    localparam logic [XLEN-1:0] DivByZeroQuot = '1;
    localparam logic [XLEN-1:0] OvfQuot       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OvfRem        = '0;

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e         op_q, op_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] special_res_q, special_res_d;
    logic [XLEN-1:0] result_q, result_d;

    mdu_op_e         op_in;
    logic            in_sign_a, in_sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            in_div0, in_ovf;
    logic [XLEN-1:0] in_special_res;

    logic            core_start, core_step;
    logic [XLEN-1:0] core_hi, core_lo;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

`ifdef MDU_FAST_MUL_EN
    logic [XLEN:0]     fast_a, fast_b;
    logic [2*XLEN-1:0] fast_p;
    logic [XLEN-1:0]   fast_res;
`endif

    // Operand conditioning for the accept cycle.
    always_comb begin
        op_in     = mdu_op_e'(op_i);
        in_sign_a = op_rs1_signed(op_in) & rs1_i[XLEN-1];
        in_sign_b = op_rs2_signed(op_in) & rs2_i[XLEN-1];
        mag_a     = in_sign_a ? -rs1_i : rs1_i;
        mag_b     = in_sign_b ? -rs2_i : rs2_i;
        in_div0   = op_is_div(op_in) && (rs2_i == '0);
        in_ovf    = op_is_div(op_in) && op_rs1_signed(op_in) &&
                    (rs1_i == OvfQuot) && (rs2_i == '1);
        if (op_is_rem(op_in)) begin
            in_special_res = in_div0 ? rs1_i : OvfRem;
        end else begin
            in_special_res = in_div0 ? DivByZeroQuot : OvfQuot;
        end
    end

`ifdef MDU_FAST_MUL_EN
    always_comb begin
        fast_a   = {op_rs1_signed(op_in) & rs1_i[XLEN-1], rs1_i};
        fast_b   = {op_rs2_signed(op_in) & rs2_i[XLEN-1], rs2_i};
        // Sign-extend to 2*XLEN; the low 2*XLEN bits of the signed product are exact.
        fast_p   = $signed((2*XLEN)'($signed(fast_a))) * $signed((2*XLEN)'($signed(fast_b)));
        fast_res = (op_in == MduMul) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif

    mdu_shift_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (core_start),
        .step_i   (core_step),
        .is_div_i (op_is_div(op_q)),
        .a_i      (mag_a),
        .b_i      (mag_b),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    // Sign correction and half selection of the finished iteration.
    always_comb begin
        prod      = {core_hi, core_lo};
        prod_fix  = (sign_a_q ^ sign_b_q) ? -prod : prod;
        quot_fix  = (sign_a_q ^ sign_b_q) ? -core_lo : core_lo;
        rem_fix   = sign_a_q ? -core_hi : core_hi;
        final_res = quot_fix;
        unique case (op_q)
            MduMul:                        final_res = prod_fix[XLEN-1:0];
            MduMulh, MduMulhsu, MduMulhu:  final_res = prod_fix[2*XLEN-1:XLEN];
            MduDiv, MduDivu:               final_res = quot_fix;
            MduRem, MduRemu:               final_res = rem_fix;
            default:                       final_res = quot_fix;
        endcase
        if (special_q) begin
            final_res = special_res_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        sign_a_d       = sign_a_q;
        sign_b_d       = sign_b_q;
        special_d      = special_q;
        special_res_d  = special_res_q;
        result_d       = result_q;
        core_start     = 1'b0;
        core_step      = 1'b0;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        result_o       = result_q;

        if (kill_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_i) begin
`ifdef MDU_FAST_MUL_EN
                        if (!op_is_div(op_in)) begin
                            result_o       = fast_res;
                            result_valid_o = 1'b1;
                            result_d       = fast_res;
                        end else begin
`else
                        begin
`endif
                            op_d          = op_in;
                            sign_a_d      = in_sign_a;
                            sign_b_d      = in_sign_b;
                            special_d     = in_div0 | in_ovf;
                            special_res_d = in_special_res;
                            cnt_d         = '0;
                            core_start    = 1'b1;
                            stall_o       = 1'b1;
                            state_d       = (in_div0 | in_ovf) ? StDone : StBusy;
                        end
                    end
                end
                StBusy: begin
                    stall_o   = 1'b1;
                    core_step = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // valid_i may still be high here for this same instruction: never restart.
                    result_valid_o = 1'b1;
                    result_o       = final_res;
                    result_d       = final_res;
                    state_d        = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            op_q          <= MduMul;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            result_q      <= result_d;
        end
    end

    assign busy_o = (state_q != StIdle);

endmodule
